// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch path and the load/store path.
//
// Handshake (both requesters): req is a level held high with its address
// and data stable until the matching one-cycle ack pulse. The requester drops
// or re-presents req in the cycle after ack. A req still high in the next
// IDLE cycle starts a new transaction.
//
// Flow: IDLE (arbitrate) -> ACCESS (WAIT_STATES+1 cycles) -> RESP (ack).
// Data wins ties unless fetch has lost STARVE_LIMIT arbitrations in a row.
//
// Optional build macro MEM_ARB_PERF_EN adds wait/transfer counters.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic [1:0]    state_dbg
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_if_wait,
  output logic [31:0]   perf_d_wait,
  output logic [31:0]   perf_xfers
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_MAX   = 3'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       fetch_wins;
  logic       data_wins;

  assign state_dbg = state;

  // Arbitration on the live request levels; only meaningful in IDLE.
  always_comb begin
    fetch_wins = 1'b0;
    data_wins  = 1'b0;
    if (state == S_IDLE) begin
      if (if_req && d_req) begin
        if (starve_cnt == STARVE_MAX) fetch_wins = 1'b1;
        else                          data_wins  = 1'b1;
      end else if (if_req) begin
        fetch_wins = 1'b1;
      end else if (d_req) begin
        data_wins = 1'b1;
      end
    end
  end

  // Main FSM: owns all registered outputs and the wait/starvation counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 2'b00;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      wait_cnt   <= 3'd0;
      starve_cnt <= 4'd0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          wait_cnt <= 3'd0;
          if (fetch_wins) begin
            grant      <= 2'b01;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= 4'd0;
            state      <= S_ACCESS;
          end else if (data_wins) begin
            grant     <= 2'b10;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= S_ACCESS;
            // Only a contested loss counts against fetch.
            if (if_req && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        S_ACCESS: begin
          if (wait_cnt == WAIT_MAX) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= S_RESP;
            if (grant[0]) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              // Stores leave the load result register untouched.
              if (!mem_we) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_RESP: begin
          grant <= 2'b00;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Wait counters: the IDLE cycle in which a requester wins is service, not waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_wait <= 32'd0;
      perf_d_wait  <= 32'd0;
      perf_xfers   <= 32'd0;
    end else begin
      if (if_req && (grant != 2'b01) && !fetch_wins)
        perf_if_wait <= perf_if_wait + 32'd1;
      if (d_req && (grant != 2'b10) && !data_wins)
        perf_d_wait <= perf_d_wait + 32'd1;
      if (if_ack || d_ack)
        perf_xfers <= perf_xfers + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and scenario checks for mem_port_arbiter,
// with a synchronous memory model and per-requester expected-data queues.
module tb_mem_port_arbiter;

  localparam int W  = 1;
  localparam int SL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        if_ack, d_ack, mem_en, mem_we;
  logic [1:0]  grant, state_dbg;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_d_wait, perf_xfers;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(W), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .state_dbg(state_dbg)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait), .perf_xfers(perf_xfers)
`endif
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] init_val(input logic [9:0] a);
    return (a == 10'h132) ? 32'h40E0_0000 : (32'h1000_0000 + 32'(a));
  endfunction

  logic [31:0] mem [0:1023];
  bit          written [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[9:0]]     <= mem_wdata;
        written[mem_addr[9:0]] <= 1'b1;
      end
      mem_rdata <= written[mem_addr[9:0]] ? mem[mem_addr[9:0]] : init_val(mem_addr[9:0]);
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] shadow [0:1023];
  logic [31:0] last_if = '0, last_d = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Pops the expected read data whenever an ack appears.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_ack && d_ack) check("ack_overlap", 32'd1, 32'd0);
      if (if_ack) begin
        if (if_exp_q.size() == 0) check("if_ack_unexpected", 32'd1, 32'd0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (d_ack) begin
        if (d_exp_q.size() == 0) check("d_ack_unexpected", 32'd1, 32'd0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    if_exp_q.delete(); d_exp_q.delete();
    last_if = '0; last_d = '0;
  endtask

  // One isolated transaction with latency, ACCESS-window and hold checks.
  task automatic do_txn(input logic is_data, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    int lat, en_cnt, first_en;
    bit done;
    @(posedge clk); #1;
    if (is_data) begin
      if (we) begin
        d_exp_q.push_back(last_d);
        shadow[addr[9:0]] = wdata;
      end else begin
        d_exp_q.push_back(exp_rd);
        last_d = exp_rd;
      end
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_exp_q.push_back(exp_rd);
      last_if = exp_rd;
      if_req = 1'b1; if_addr = addr;
    end
    done = 1'b0; lat = 0; en_cnt = 0; first_en = -1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (first_en < 0) first_en = n;
        check("acc_grant", 32'(grant), is_data ? 32'd2 : 32'd1);
        check("acc_we", 32'(mem_we), 32'(is_data & we));
        check("acc_addr", mem_addr, addr);
        if (is_data && we) check("acc_wdata", mem_wdata, wdata);
      end
      if (is_data ? d_ack : if_ack) begin
        done = 1'b1;
        lat = n;
      end
    end
    if (!done) begin
      check("txn_timeout", 32'd0, 32'd1);
    end else begin
      check("ack_latency", 32'(lat), 32'(W + 2));
      check("en_cycles", 32'(en_cnt), 32'(W + 1));
      check("en_first", 32'(first_en), 32'd1);
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("if_rdata_hold", if_rdata, last_if);
    check("d_rdata_hold", d_rdata, last_d);
    check("grant_idle", 32'(grant), 32'd0);
  endtask

  // Waits for the next ack on either side; returns 1 for fetch, 0 for data.
  task automatic wait_any_ack(output bit is_fetch, output int at_cyc, output bit ok);
    ok = 1'b0; is_fetch = 1'b0; at_cyc = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        ok = 1'b1;
        is_fetch = if_ack;
        at_cyc = cyc;
      end
    end
    if (!ok) check("ack_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit f, ok;
    int c0, c;
    bit exp_seq [10];

    for (int i = 0; i < 1024; i++) shadow[i] = init_val(10'(i));

    vecs[0] = '{1'b0, 1'b0, 32'h132, 32'h0,         32'h40E0_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h020, 32'h0,         32'h1000_0020};
    vecs[2] = '{1'b1, 1'b1, 32'h030, 32'h1234_5678, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h030, 32'h0,         32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 32'h3FF, 32'h0,         32'h1000_03FF};
    vecs[5] = '{1'b1, 1'b1, 32'h010, 32'hDEAD_BEAF, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h010, 32'h0,         32'hDEAD_BEAF};
    vecs[7] = '{1'b0, 1'b0, 32'h000, 32'h0,         32'h1000_0000};

    // Reset state.
    reset_dut();
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_acks", 32'({if_ack, d_ack}), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Table-driven single transactions.
    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // Simultaneous fetch and load: data first, then fetch.
    reset_dut();
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h132;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    d_exp_q.push_back(shadow[10'h10]);  last_d  = shadow[10'h10];
    if_exp_q.push_back(shadow[10'h132]); last_if = shadow[10'h132];
    wait_any_ack(f, c, ok);
    if (ok) begin
      check("sim_first_is_data", 32'(f), 32'd0);
      check("sim_d_ack_cycle", 32'(c - c0), 32'(W + 2));
    end
    @(posedge clk); #1 d_req = 1'b0;
    wait_any_ack(f, c, ok);
    if (ok) begin
      check("sim_second_is_fetch", 32'(f), 32'd1);
      check("sim_if_ack_cycle", 32'(c - c0), 32'(2 * W + 5));
    end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    check("perf_if_wait", perf_if_wait, 32'd4);
    check("perf_xfers", perf_xfers, 32'd2);
`endif

    // Starvation guard: both held high, fetch forced after SL data wins.
    reset_dut();
    for (int k = 0; k < 10; k++) exp_seq[k] = ((k % (SL + 1)) == SL);
    for (int k = 0; k < 10; k++) begin
      if (exp_seq[k]) if_exp_q.push_back(shadow[10'h132]);
      else            d_exp_q.push_back(shadow[10'h20]);
    end
    last_if = shadow[10'h132]; last_d = shadow[10'h20];
    if_req = 1'b1; if_addr = 32'h132;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      wait_any_ack(f, c, ok);
      if (ok) check($sformatf("starve_seq_%0d", k), 32'(f), 32'(exp_seq[k]));
    end
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;

    // Reset in the second ACCESS cycle of a fetch abandons it.
    reset_dut();
    if_req = 1'b1; if_addr = 32'h132;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_access", 32'({mem_en, grant}), 32'b101);
    rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_if_ack", 32'(if_ack), 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    do_txn(1'b0, 1'b0, 32'h132, 32'h0, 32'h40E0_0000);

    // Random single transactions against the shadow model.
    for (int i = 0; i < 8; i++) begin
      logic        is_d, w;
      logic [31:0] a, wd;
      is_d = 1'($urandom_range(0, 1));
      w    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      a    = 32'($urandom_range(0, 63));
      wd   = $urandom;
      do_txn(is_d, w, a, wd, shadow[a[9:0]]);
    end

    repeat (3) @(negedge clk);
    check("if_q_drained", 32'(if_exp_q.size()), 32'd0);
    check("d_q_drained", 32'(d_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
